// File: rtl/sfifo_wr_packer_if.sv
// Handshake and FIFO write-port bundle for the write-side width packer.
// master = stream source / FIFO side, slave = the packer.
interface sfifo_wr_packer_if #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4
);
  localparam int unsigned DATA_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned CNT_WIDTH  = $clog2(RATIO) + 1;

  logic                  in_valid;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  flush;
  logic                  sfifo_full;
  logic                  wr;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic [CNT_WIDTH-1:0]  fifo_wcnt;
  logic                  fifo_wlast;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_last, flush, sfifo_full,
    input  in_ready, wr, fifo_wdata, fifo_wcnt, fifo_wlast, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, sfifo_full,
    output in_ready, wr, fifo_wdata, fifo_wcnt, fifo_wlast, busy
  );
endinterface

// File: rtl/sfifo_wr_packer.sv
// Packs RATIO narrow beats little-endian into one FIFO word; closes partial
// words on in_last/flush and back-pressures on sfifo_full via acc + output reg.
module sfifo_wr_packer #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4
) (
  input  logic             wclk,
  input  logic             rst_n,
  sfifo_wr_packer_if.slave bus
);
  localparam int unsigned DATA_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned CNT_WIDTH  = $clog2(RATIO) + 1;

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  acc_last_q, acc_last_d;
  logic                  acc_full_q, acc_full_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;

  logic                  wr_c;
  logic                  out_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] merged;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_data;
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic                  word_last;

  assign wr_c     = out_valid_q & ~bus.sfifo_full;
  assign out_free = ~out_valid_q | wr_c;
  assign accept   = bus.in_valid & in_ready_q;

  // Drop the incoming beat into the lane indexed by the current count
  always_comb begin
    merged = acc_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt_q == CNT_WIDTH'(k)) merged[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
    end
  end

  // A word closes on the last lane, in_last, or flush; a lone flush closes only a partial word
  always_comb begin
    word_done = 1'b0;
    word_data = acc_q;
    word_cnt  = cnt_q;
    word_last = 1'b0;
    if (!acc_full_q) begin
      if (accept) begin
        word_data = merged;
        word_cnt  = cnt_q + CNT_WIDTH'(1);
        word_last = bus.in_last;
        word_done = (cnt_q == CNT_WIDTH'(RATIO - 1)) | bus.in_last | bus.flush;
      end else if (bus.flush && (cnt_q != '0)) begin
        word_done = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_last_d  = acc_last_q;
    acc_full_d  = acc_full_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q & ~wr_c;

    if (acc_full_q) begin
      // Parked word moves to the output register as soon as it frees
      if (out_free) begin
        out_data_d  = acc_q;
        out_cnt_d   = cnt_q;
        out_last_d  = acc_last_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        acc_last_d  = 1'b0;
        acc_full_d  = 1'b0;
      end
    end else if (word_done) begin
      if (out_free) begin
        out_data_d  = word_data;
        out_cnt_d   = word_cnt;
        out_last_d  = word_last;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        acc_last_d  = 1'b0;
      end else begin
        acc_d       = word_data;
        cnt_d       = word_cnt;
        acc_last_d  = word_last;
        acc_full_d  = 1'b1;
      end
    end else if (accept) begin
      acc_d = merged;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    in_ready_d = ~acc_full_d;
    busy_d     = (cnt_d != '0) | acc_full_d | out_valid_d;
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_last_q  <= 1'b0;
      acc_full_q  <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_last_q  <= acc_last_d;
      acc_full_q  <= acc_full_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wr         = wr_c;
  assign bus.fifo_wdata = out_data_q;
  assign bus.fifo_wcnt  = out_cnt_q;
  assign bus.fifo_wlast = out_last_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/sfifo_wr_packer.md
# sfifo_wr_packer

Write-side width packer feeding the synchronous FIFO. It accepts a narrow input stream under a valid/ready handshake and packs RATIO consecutive beats, little-endian, into one DATA_WIDTH word. It closes partial words on `in_last` or `flush`. It drives the FIFO write port (`wr` and data) and back-pressures on `sfifo_full` through a two-deep (accumulator + output register) buffer.

## Interface
- IN_WIDTH, 8: width of one input beat.
- RATIO, 4: beats per FIFO word; power of two, ≥2.
- DATA_WIDTH, IN_WIDTH*RATIO: derived, not overridable; must equal the FIFO DATA_WIDTH.
- CNT_WIDTH, $clog2(RATIO)+1: derived; width of the lane count.

Ports:
- wclk  in  1  write-domain clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat present.
- in_data  in  IN_WIDTH  input beat.
- in_last  in  1  beat is the final beat of a packet; closes the current word.
- in_ready  out  1  block can accept a beat; registered.
- flush  in  1  single-cycle request to close a partial word.
- sfifo_full  in  1  FIFO full flag.
- wr  out  1  FIFO write strobe; combinational, equal to out_valid & ~sfifo_full.
- fifo_wdata  out  DATA_WIDTH  packed word to the FIFO data input.
- fifo_wcnt  out  CNT_WIDTH  number of valid lanes in fifo_wdata, 1..RATIO.
- fifo_wlast  out  1  word was closed by in_last.
- busy  out  1  accumulator holds ≥1 lane, or the output register is occupied.

## Operation
- Accept: a beat is accepted on an edge where in_valid & in_ready.
- Lane placement: lane k = bits [k*IN_WIDTH +: IN_WIDTH]. The first beat of a word goes to lane 0. Unfilled lanes are 0.
- State:
  - acc: data register.
  - cnt: 0..RATIO-1.
  - acc_last flag.
  - acc_full flag: completed word waiting.
  - Output register: out_data, out_cnt, out_last, out_valid.
- Word completion: an accepted beat completes a word when cnt==RATIO-1, or in_last=1, or flush=1 on the same cycle.
  - The completing beat is included in the word.
  - fifo_wlast = in_last of that beat.
- Flush without an accepted beat:
  - Closes acc if cnt>0, with wlast=0.
  - If cnt==0, or acc_full=1, flush is ignored; it is not queued.
- Completed-word routing:
  - If the output register is free (out_valid=0, or wr=1 this cycle), the word loads it directly; cnt←0; acc cleared.
  - Otherwise acc_full←1 and the word stays in acc.
- Draining: while acc_full=1, in_ready=0. On the first edge where the output register frees, acc moves to it; acc_full←0; in_ready←1.
- out_valid clears on a wr edge unless it is reloaded on the same edge.
- Simultaneous wr and new completed word: the output register reloads with no bubble.
- Reset (async, any time including mid-word): in_ready=1, wr=0, fifo_wdata=0, fifo_wcnt=0, fifo_wlast=0, busy=0. Partial data is discarded.

## Timing
- Completing beat accepted at edge k, with the output register free:
  - out_valid=1 after edge k.
  - wr=1 in cycle k+1 if sfifo_full=0.
  - FIFO write at edge k+1.
- Full-rate streaming (sfifo_full=0): one word written every RATIO cycles; in_ready stays 1.
- sfifo_full held high: the output register fills, then acc fills. in_ready drops the cycle after the second completed word is accepted. No beat is lost or duplicated.
- sfifo_full deasserts at cycle j: wr=1 in cycle j; in_ready=1 from cycle j+1.
- wr never asserts while sfifo_full=1, so the FIFO never overflows from this block.

## Test plan
- Stream in_data 0x11,0x22,0x33,0x44 back-to-back, sfifo_full=0 -> one wr with fifo_wdata=0x44332211, fifo_wcnt=4, fifo_wlast=0, one cycle after the fourth beat.
- Send 0xAA, then 0xBB with in_last=1 -> fifo_wdata=0x0000BBAA, fifo_wcnt=2, fifo_wlast=1. The next word starts at lane 0.
- Send 0x01,0x02,0x03, idle 3 cycles, then a flush pulse -> fifo_wdata=0x00030201, fifo_wcnt=3, fifo_wlast=0. A second flush with cnt=0 produces no wr.
- Hold sfifo_full=1 and stream 12 beats 0x00..0x0B -> in_ready drops after beat 0x07, no wr while full. Release full -> words 0x03020100 then 0x07060504 on consecutive wr cycles; beats 0x08..0x0B are then accepted. All 12 beats reach the FIFO in order.
- Assert rst_n=0 mid-word after 2 beats, with out_valid=1 -> all outputs take their reset values immediately. After release, a 4-beat stream 0xA0..0xA3 yields exactly one word, 0xA3A2A1A0.
- flush and in_valid with in_data=0x5C on the same cycle as the 1st lane -> fifo_wdata=0x0000005C, fifo_wcnt=1.
